// File: rtl/partition_sweep_checker.sv
// Exhaustive sweep of one partition: drives every input vector to the exact and approximate
// instances, then accumulates mismatch, Hamming, summed and maximum absolute error metrics.
module partition_sweep_checker #(
   parameter int N_IN   = 7,
   parameter int N_OUT  = 4,
   parameter int SETTLE = 1
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start,
   output logic [N_IN-1:0]                 pi,
   input  logic [N_OUT-1:0]                po_exact,
   input  logic [N_OUT-1:0]                po_approx,
   output logic                            busy,
   output logic                            done,
   output logic                            sample_valid,
   output logic [N_IN:0]                   mismatch_cnt,
   output logic [N_IN+$clog2(N_OUT):0]     bit_err_cnt,
   output logic [N_IN+N_OUT-1:0]           err_sum,
   output logic [N_OUT-1:0]                max_abs_err
);

   localparam int MW = N_IN + 1;
   localparam int BW = N_IN + $clog2(N_OUT) + 1;
   localparam int EW = N_IN + N_OUT;
   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

   typedef enum logic [1:0] {S_IDLE, S_APPLY, S_SAMPLE, S_DONE} state_t;

   state_t            r_state;
   logic              r_start;
   logic [SW-1:0]     r_settle;
   logic [N_IN-1:0]   r_pi;
   logic              r_busy;
   logic              r_done;
   logic              r_sv;
   logic [MW-1:0]     r_mis;
   logic [BW-1:0]     r_bits;
   logic [EW-1:0]     r_sum;
   logic [N_OUT-1:0]  r_max;

   logic [N_OUT:0]    w_diff;
   logic [N_OUT-1:0]  w_abs;
   logic [N_OUT-1:0]  w_xor;
   logic [BW-1:0]     w_pop;

   function automatic logic [BW-1:0] popcount(input logic [N_OUT-1:0] v);
      logic [BW-1:0] c;
      c = '0;
      for (int unsigned k = 0; k < N_OUT; k++) c = c + BW'(v[k]);
      return c;
   endfunction

   // Difference at N_OUT+1 bits; negating the low N_OUT bits gives the truncated magnitude.
   always_comb begin
      w_diff = {1'b0, po_exact} - {1'b0, po_approx};
      w_abs  = w_diff[N_OUT] ? -w_diff[N_OUT-1:0] : w_diff[N_OUT-1:0];
      w_xor  = po_exact ^ po_approx;
      w_pop  = popcount(w_xor);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_start  <= 1'b0;
         r_settle <= '0;
         r_pi     <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_sv     <= 1'b0;
         r_mis    <= '0;
         r_bits   <= '0;
         r_sum    <= '0;
         r_max    <= '0;
      end else begin
         // Requests are captured only while idle or done, so a pulse during a sweep is dropped.
         r_start <= start && (r_state == S_IDLE || r_state == S_DONE);
         r_sv    <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (r_start) begin
                  r_state  <= S_APPLY;
                  r_pi     <= '0;
                  r_settle <= '0;
                  r_mis    <= '0;
                  r_bits   <= '0;
                  r_sum    <= '0;
                  r_max    <= '0;
                  r_busy   <= 1'b1;
                  r_done   <= 1'b0;
               end
            end
            S_APPLY: begin
               if (r_settle == SETTLE_LAST) begin
                  r_state <= S_SAMPLE;
                  r_sv    <= 1'b1;
               end else begin
                  r_settle <= r_settle + SW'(1);
               end
            end
            S_SAMPLE: begin
               if (w_xor != '0) r_mis <= r_mis + MW'(1);
               r_bits <= r_bits + w_pop;
               r_sum  <= r_sum + EW'(w_abs);
               if (w_abs > r_max) r_max <= w_abs;
               if (&r_pi) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_pi     <= r_pi + N_IN'(1);
                  r_settle <= '0;
                  r_state  <= S_APPLY;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign pi           = r_pi;
   assign busy         = r_busy;
   assign done         = r_done;
   assign sample_valid = r_sv;
   assign mismatch_cnt = r_mis;
   assign bit_err_cnt  = r_bits;
   assign err_sum      = r_sum;
   assign max_abs_err  = r_max;

endmodule
